// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller: generates stall and clear pins for the F/D and D/E registers.
// Optional perf counters (stall_cycles, flush_events) are built when PHC_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int LW           = 8,
  parameter int FLUSH_CYCLES = 1
`ifdef PHC_PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branch_taken_e,
  input  logic          load_use_d,
  input  logic          vec_start_e,
  input  logic [LW-1:0] vec_len,
  output logic          stall_f,
  output logic          stall_d,
  output logic          stall_e,
  output logic          flush_d,
  output logic          flush_e,
  output logic          busy
`ifdef PHC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_VSTALL = 2'd2
  } state_t;

  localparam logic [2:0] LP_FRELOAD = 3'(FLUSH_CYCLES - 1);

  state_t        r_state;
  logic [LW-1:0] r_cnt;
  logic [2:0]    r_fcnt;

  logic w_sf;
  logic w_sd;
  logic w_se;
  logic w_fd;
  logic w_fe;
  logic w_br_acc;
  logic w_vec_go;

  assign w_vec_go = vec_start_e &&
                    (vec_len >= LW'(2));

  // Output decode: pure function of state and hazard inputs, muted in reset
  always_comb begin
    w_sf     = 1'b0;
    w_sd     = 1'b0;
    w_se     = 1'b0;
    w_fd     = 1'b0;
    w_fe     = 1'b0;
    w_br_acc = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_RUN: begin
          if (branch_taken_e) begin
            w_fd     = 1'b1;
            w_fe     = 1'b1;
            w_br_acc = 1'b1;
          end else if (w_vec_go) begin
            w_sf = 1'b1;
            w_sd = 1'b1;
            w_se = 1'b1;
          end else if (load_use_d) begin
            w_sf = 1'b1;
            w_sd = 1'b1;
            w_fe = 1'b1;
          end
        end
        S_VSTALL: begin
          w_sf = 1'b1;
          w_sd = 1'b1;
          w_se = 1'b1;
        end
        S_FLUSH: begin
          w_fd     = 1'b1;
          w_fe     = branch_taken_e;
          w_br_acc = branch_taken_e;
        end
        default: ;
      endcase
    end
  end

  assign stall_f = w_sf;
  assign stall_d = w_sd;
  assign stall_e = w_se;
  assign flush_d = w_fd;
  assign flush_e = w_fe;
  assign busy    = !reset && (r_state != S_RUN);

  // State and countdown registers; a branch in FLUSH restarts the window
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_fcnt  <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (branch_taken_e) begin
            if (FLUSH_CYCLES > 1) begin
              r_state <= S_FLUSH;
              r_fcnt  <= LP_FRELOAD;
            end
          end else if (w_vec_go) begin
            r_state <= S_VSTALL;
            r_cnt   <= vec_len - LW'(2);
          end
        end
        S_VSTALL: begin
          if (r_cnt == '0) begin
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt - LW'(1);
          end
        end
        S_FLUSH: begin
          if (branch_taken_e) begin
            r_fcnt <= LP_FRELOAD;
          end else if (r_fcnt == 3'd1) begin
            r_state <= S_RUN;
          end else begin
            r_fcnt <= r_fcnt - 3'd1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef PHC_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  // Saturating perf counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_sf && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_br_acc && !(&r_flush_events)) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=3).
// Reference model tracks remaining freeze/flush cycles as plain integers.
module tb_pipe_hazard_ctrl;

  localparam int FC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       br;
  logic       lu;
  logic       vs;
  logic [7:0] len;
  logic       sf, sd, se, fd, fe, bsy;
`ifdef PHC_PERF_CNT_EN
  logic [31:0] st_cyc;
  logic [31:0] fl_evt;
`endif

  pipe_hazard_ctrl #(
    .LW(8),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .branch_taken_e(br),
    .load_use_d(lu),
    .vec_start_e(vs),
    .vec_len(len),
    .stall_f(sf),
    .stall_d(sd),
    .stall_e(se),
    .flush_d(fd),
    .flush_e(fe),
    .busy(bsy)
`ifdef PHC_PERF_CNT_EN
    ,
    .stall_cycles(st_cyc),
    .flush_events(fl_evt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_frz = 0, m_fl = 0, nx_frz = 0, nx_fl = 0;
  longint m_st = 0, m_fe = 0, nx_st = 0, nx_fe = 0;
  logic [5:0] exp_o;
  wire  [5:0] obs = {sf, sd, se, fd, fe, bsy};

  task automatic apply(input logic b, input logic l,
                       input logic v, input logic [7:0] n,
                       input logic r);
    logic e_sf, e_sd, e_se, e_fd, e_fe, e_bsy;
    br = b; lu = l; vs = v; len = n; reset = r;
    {e_sf, e_sd, e_se, e_fd, e_fe, e_bsy} = '0;
    nx_frz = m_frz; nx_fl = m_fl;
    nx_st = m_st; nx_fe = m_fe;
    if (r) begin
      nx_frz = 0; nx_fl = 0; nx_st = 0; nx_fe = 0;
    end else begin
      e_bsy = (m_frz > 0) || (m_fl > 0);
      if (m_frz > 0) begin
        {e_sf, e_sd, e_se} = 3'b111;
        nx_frz = m_frz - 1;
      end else if (m_fl > 0) begin
        e_fd = 1'b1;
        if (b) begin
          e_fe = 1'b1; nx_fl = FC - 1; nx_fe = m_fe + 1;
        end else begin
          nx_fl = m_fl - 1;
        end
      end else if (b) begin
        e_fd = 1'b1; e_fe = 1'b1;
        nx_fl = FC - 1; nx_fe = m_fe + 1;
      end else if (v && n >= 2) begin
        {e_sf, e_sd, e_se} = 3'b111;
        nx_frz = int'(n) - 1;
      end else if (l) begin
        e_sf = 1'b1; e_sd = 1'b1; e_fe = 1'b1;
      end
      if (e_sf) nx_st = m_st + 1;
    end
    exp_o = {e_sf, e_sd, e_se, e_fd, e_fe, e_bsy};
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    m_frz = nx_frz; m_fl = nx_fl;
    m_st = nx_st; m_fe = nx_fe;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 1, 8'd5, 1);
      n_tests++;
      if (obs !== 6'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d obs=%b exp=%b", i, obs, 6'b0);
      end
      tick();
    end
    apply(0, 0, 0, 8'd0, 0);
    n_tests++;
    if (obs !== exp_o) begin
      n_fail++;
      $display("FAIL reset_release obs=%b exp=%b", obs, exp_o);
    end
    tick();
  endtask

  task automatic test_load_use;
    apply(0, 1, 0, 8'd0, 0);
    n_tests++;
    if (obs !== exp_o || obs !== 6'b110010) begin
      n_fail++;
      $display("FAIL load_use obs=%b exp=%b", obs, exp_o);
    end
    tick();
    apply(0, 0, 0, 8'd0, 0);
    n_tests++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL load_use_after obs=%b exp=%b", obs, 6'b0);
    end
    tick();
  endtask

  task automatic test_vec;
    int nst, nb;
    nst = 0; nb = 0;
    apply(0, 0, 0, 8'd0, 1);
    tick();
    for (int i = 0; i < 7; i++) begin
      if (i == 0) apply(0, 0, 1, 8'd4, 0);
      else        apply(i == 2, 0, 0, 8'd0, 0);
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL vec cyc%0d obs=%b exp=%b", i, obs, exp_o);
      end
      nst += int'(se && sf);
      nb  += int'(bsy);
      tick();
    end
    n_tests++;
    if (nst != 4 || nb != 3) begin
      n_fail++;
      $display("FAIL vec_len stall=%0d busy=%0d exp 4/3", nst, nb);
    end
`ifdef PHC_PERF_CNT_EN
    n_tests++;
    if (st_cyc !== 32'd4 || fl_evt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_vec st=%0d fl=%0d exp 4/0", st_cyc, fl_evt);
    end
`endif
    apply(0, 0, 1, 8'd1, 0);
    n_tests++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL vec_len1 obs=%b exp=%b", obs, 6'b0);
    end
    tick();
    apply(0, 0, 0, 8'd0, 1);
    tick();
`ifdef PHC_PERF_CNT_EN
    n_tests++;
    if (st_cyc !== 32'd0 || fl_evt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_clr st=%0d fl=%0d exp 0/0", st_cyc, fl_evt);
    end
`endif
  endtask

  task automatic test_branch;
    int nfd, nfe;
    for (int k = 0; k < 2; k++) begin
      nfd = 0; nfe = 0;
      for (int i = 0; i < 6; i++) begin
        apply(i == 0 || (k == 1 && i == 1), 0, 0, 8'd0, 0);
        n_tests++;
        if (obs !== exp_o) begin
          n_fail++;
          $display("FAIL branch%0d cyc%0d obs=%b exp=%b", k, i, obs, exp_o);
        end
        nfd += int'(fd);
        nfe += int'(fe);
        tick();
      end
      n_tests++;
      if (nfd != FC + k || nfe != 1 + k) begin
        n_fail++;
        $display("FAIL branch_len%0d fd=%0d fe=%0d exp %0d/%0d",
                 k, nfd, nfe, FC + k, 1 + k);
      end
    end
  endtask

  task automatic test_priority;
    apply(1, 1, 1, 8'd5, 0);
    n_tests++;
    if (obs !== exp_o || obs !== 6'b000110) begin
      n_fail++;
      $display("FAIL priority obs=%b exp=%b", obs, 6'b000110);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 8'd0, 0);
      n_tests++;
      if (obs !== exp_o || se !== 1'b0) begin
        n_fail++;
        $display("FAIL priority_after cyc%0d obs=%b exp=%b", i, obs, exp_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    apply(0, 0, 1, 8'd10, 0);
    tick();
    apply(0, 0, 0, 8'd0, 0);
    tick();
    apply(1, 1, 0, 8'd0, 1);
    n_tests++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid obs=%b exp=%b", obs, 6'b0);
    end
    tick();
    apply(0, 0, 0, 8'd0, 0);
    n_tests++;
    if (obs !== 6'b0 || obs !== exp_o) begin
      n_fail++;
      $display("FAIL reset_mid_after obs=%b exp=%b", obs, 6'b0);
    end
    tick();
  endtask

  task automatic test_random;
    logic r, b, l, v;
    logic [7:0] n;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 59) == 0);
      b = ($urandom_range(0, 6) == 0);
      l = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 5) == 0);
      n = 8'($urandom_range(0, 12));
      apply(b, l, v, n, r);
      n_tests++;
      if (obs !== exp_o || (se && fe)) begin
        n_fail++;
        $display("FAIL random cyc%0d obs=%b exp=%b", i, obs, exp_o);
      end
      tick();
`ifdef PHC_PERF_CNT_EN
      n_tests++;
      if (st_cyc !== 32'(m_st) || fl_evt !== 32'(m_fe)) begin
        n_fail++;
        $display("FAIL perf_rand cyc%0d st=%0d fl=%0d exp %0d/%0d",
                 i, st_cyc, fl_evt, m_st, m_fe);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; br = 1'b0; lu = 1'b0;
    vs = 1'b0; len = 8'd0;
    test_reset();
    test_load_use();
    test_vec();
    test_branch();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
